spmm_bsr_cmd_issuer: RTL

- Initiator side of the spmm_bsr engine start/busy/done interface.
- Accepts SpMM command descriptors over a valid/ready port and queues them in a small FIFO.
- Sequences the descriptors one at a time into the engine and captures the engine checksum.
- Returns a tagged response over a second valid/ready port. Sits between the attention command decoder and the spmm_bsr engine.

---
 rtl/spmm_bsr_pkg.sv | 34 +++
 rtl/spmm_cmd_fifo.sv | 47 ++++
 rtl/spmm_bsr_cmd_issuer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spmm_bsr_pkg.sv
// Shared types for the spmm_bsr command issuer: response status codes, the
// issuer FSM states and the queued command descriptor.
package spmm_bsr_pkg;

  // Widest tag a descriptor can carry; instances use TAG_W <= this.
  localparam int SPMM_TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_ZERO_DIM = 2'd1,
    ST_TIMEOUT  = 2'd2
  } rsp_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP,
    S_DRAIN
  } issuer_state_e;

  typedef struct packed {
    logic [SPMM_TAG_MAX_W-1:0] tag;
    logic [15:0]               m_rows;
    logic [15:0]               s_tokens;
    logic [15:0]               head_dim;
  } spmm_cmd_t;

  function automatic logic has_zero_dim(input spmm_cmd_t c);
    return (c.m_rows == 16'd0) || (c.s_tokens == 16'd0) || (c.head_dim == 16'd0);
  endfunction

endpackage

// File: rtl/spmm_cmd_fifo.sv
// Synchronous FIFO of command descriptors; head is visible combinationally on dout.
module spmm_cmd_fifo
  import spmm_bsr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  spmm_cmd_t                din,
  output spmm_cmd_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  spmm_cmd_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spmm_bsr_cmd_issuer.sv
// Queues SpMM descriptors and runs them one at a time through the spmm_bsr
// engine, returning a tagged checksum/status response for each.
module spmm_bsr_cmd_issuer
  import spmm_bsr_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TMO_W     = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic [15:0]       cmd_m_rows,
  input  logic [15:0]       cmd_s_tokens,
  input  logic [15:0]       cmd_head_dim,
  input  logic [TMO_W-1:0]  cfg_timeout,
  output logic              eng_start,
  output logic [15:0]       eng_m_rows,
  output logic [15:0]       eng_s_tokens,
  output logic [15:0]       eng_head_dim,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic [63:0]       eng_checksum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [63:0]       rsp_checksum,
  output logic [1:0]        rsp_status,
  output logic              idle
);
  localparam int CW = $clog2(CMD_DEPTH) + 1;

  issuer_state_e state, state_nxt;
  spmm_cmd_t     fifo_din, fifo_head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [TMO_W-1:0] wdog;
  logic          wdog_hit;
  logic          drain;
  logic [TAG_W-1:0] tag_q;
  rsp_status_e   status_q;
  logic          unused_ok;

  assign fifo_din  = '{tag: SPMM_TAG_MAX_W'(cmd_tag), m_rows: cmd_m_rows,
                       s_tokens: cmd_s_tokens, head_dim: cmd_head_dim};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  spmm_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wdog_hit   = (cfg_timeout != '0) && (wdog == cfg_timeout - TMO_W'(1));
  assign eng_start  = (state == S_ISSUE);
  assign rsp_valid  = (state == S_RESP);
  assign rsp_tag    = tag_q;
  assign rsp_status = status_q;
  assign idle       = fifo_empty && (state == S_IDLE);
  assign unused_ok  = ^{eng_busy, fifo_count, fifo_head.tag};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // eng_done has priority over the watchdog expiring in the same WAIT cycle.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = has_zero_dim(fifo_head) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (eng_done)      state_nxt = S_CAPTURE;
        else if (wdog_hit) state_nxt = S_RESP;
      end
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) state_nxt = drain ? S_DRAIN : S_IDLE;
      S_DRAIN:   if (eng_done) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eng_m_rows   <= '0;
      eng_s_tokens <= '0;
      eng_head_dim <= '0;
      tag_q        <= '0;
      rsp_checksum <= '0;
      status_q     <= ST_OK;
      wdog         <= '0;
      drain        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            eng_m_rows   <= fifo_head.m_rows;
            eng_s_tokens <= fifo_head.s_tokens;
            eng_head_dim <= fifo_head.head_dim;
            tag_q        <= TAG_W'(fifo_head.tag);
            if (has_zero_dim(fifo_head)) begin
              rsp_checksum <= '0;
              status_q     <= ST_ZERO_DIM;
            end
          end
        end
        S_ISSUE: wdog <= '0;
        S_WAIT: begin
          if (wdog != '1) wdog <= wdog + 1'b1;
          // A timed-out engine is still running; its late done must be absorbed.
          if (!eng_done && wdog_hit) begin
            rsp_checksum <= '0;
            status_q     <= ST_TIMEOUT;
            drain        <= 1'b1;
          end
        end
        S_CAPTURE: begin
          rsp_checksum <= eng_checksum;
          status_q     <= ST_OK;
        end
        S_DRAIN: if (eng_done) drain <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
